// File: rtl/execute_stage.sv
// RV32 execute stage: forwarding, ALU, branch redirect, EX/MEM register.
// Define EX_FORWARD_EN to build the operand forwarding muxes.
module execute_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic [2:0]      alucontrol,
  input  logic            alusrc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pcplus4,
  input  logic [REGW-1:0] rd,
  input  logic            regwrite,
  input  logic            memwrite,
  input  logic            branch,
  input  logic            jump,
  input  logic [1:0]      resultsrc,
  input  logic [1:0]      forward_a,
  input  logic [1:0]      forward_b,
  input  logic [XLEN-1:0] wb_result,
  input  logic            stall,
  input  logic            flush,
  output logic            pcsrc,
  output logic [XLEN-1:0] pc_target,
  output logic [XLEN-1:0] alu_result_q,
  output logic [XLEN-1:0] write_data_q,
  output logic [XLEN-1:0] pcplus4_q,
  output logic [REGW-1:0] rd_q,
  output logic            regwrite_q,
  output logic            memwrite_q,
  output logic            valid_q,
  output logic [1:0]      resultsrc_q
);

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] diff;
  logic [XLEN-1:0] alu_d;
  logic            zero;
  logic            lt;

`ifdef EX_FORWARD_EN
  always_comb begin
    op_a = rs1_data;
    case (forward_a)
      2'b10:   op_a = alu_result_q;
      2'b01:   op_a = wb_result;
      default: op_a = rs1_data;
    endcase
  end

  always_comb begin
    fwd_b = rs2_data;
    case (forward_b)
      2'b10:   fwd_b = alu_result_q;
      2'b01:   fwd_b = wb_result;
      default: fwd_b = rs2_data;
    endcase
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{forward_a, forward_b, wb_result};
  assign op_a  = rs1_data;
  assign fwd_b = rs2_data;
`endif

  assign op_b = alusrc ? imm : fwd_b;
  assign diff = op_a - op_b;
  assign zero = (diff == '0);
  assign lt   = $signed(op_a) < $signed(op_b);

  always_comb begin
    alu_d = '0;
    case (alucontrol)
      3'b000:  alu_d = op_a + op_b;
      3'b001:  alu_d = diff;
      3'b010:  alu_d = op_a & op_b;
      3'b011:  alu_d = op_a | op_b;
      3'b101:  alu_d = {{(XLEN-1){1'b0}}, lt};
      default: alu_d = '0;
    endcase
  end

  assign pcsrc     = valid_in & ((branch & zero) | jump);
  assign pc_target = pc + imm;

  // flush beats stall so a squashed slot never survives a held pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_q <= '0;
      write_data_q <= '0;
      pcplus4_q    <= '0;
      rd_q         <= '0;
      regwrite_q   <= 1'b0;
      memwrite_q   <= 1'b0;
      valid_q      <= 1'b0;
      resultsrc_q  <= '0;
    end else if (flush) begin
      alu_result_q <= '0;
      write_data_q <= '0;
      pcplus4_q    <= '0;
      rd_q         <= '0;
      regwrite_q   <= 1'b0;
      memwrite_q   <= 1'b0;
      valid_q      <= 1'b0;
      resultsrc_q  <= '0;
    end else if (!stall) begin
      alu_result_q <= alu_d;
      write_data_q <= fwd_b;
      pcplus4_q    <= pcplus4;
      rd_q         <= rd;
      regwrite_q   <= regwrite & valid_in;
      memwrite_q   <= memwrite & valid_in;
      valid_q      <= valid_in;
      resultsrc_q  <= resultsrc;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Randomized bench for execute_stage against a behavioural model.
// Model follows EX_FORWARD_EN the same way the build does.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [2:0]  alucontrol;
  logic        alusrc;
  logic [31:0] rs1_data, rs2_data, imm, pc, pcplus4;
  logic [4:0]  rd;
  logic        regwrite, memwrite, branch, jump;
  logic [1:0]  resultsrc, forward_a, forward_b;
  logic [31:0] wb_result;
  logic        stall, flush;
  logic        pcsrc;
  logic [31:0] pc_target, alu_result_q, write_data_q, pcplus4_q;
  logic [4:0]  rd_q;
  logic        regwrite_q, memwrite_q, valid_q;
  logic [1:0]  resultsrc_q;

  int errors = 0;
  int checks = 0;

  // model of the EX/MEM register contents
  logic [31:0] m_alu, m_wd, m_pc4;
  logic [4:0]  m_rd;
  logic        m_rw, m_mw, m_v;
  logic [1:0]  m_rs;

  execute_stage #(.XLEN(32), .REGW(5)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .alucontrol(alucontrol), .alusrc(alusrc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .pc(pc), .pcplus4(pcplus4), .rd(rd),
    .regwrite(regwrite), .memwrite(memwrite),
    .branch(branch), .jump(jump), .resultsrc(resultsrc),
    .forward_a(forward_a), .forward_b(forward_b),
    .wb_result(wb_result), .stall(stall), .flush(flush),
    .pcsrc(pcsrc), .pc_target(pc_target),
    .alu_result_q(alu_result_q), .write_data_q(write_data_q),
    .pcplus4_q(pcplus4_q), .rd_q(rd_q),
    .regwrite_q(regwrite_q), .memwrite_q(memwrite_q),
    .valid_q(valid_q), .resultsrc_q(resultsrc_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] sel,
                                      input logic [31:0] regv);
`ifdef EX_FORWARD_EN
    if (sel == 2'b10) return m_alu;
    if (sel == 2'b01) return wb_result;
`endif
    return regv;
  endfunction

  function automatic logic [31:0] opa();
    return fwd(forward_a, rs1_data);
  endfunction

  function automatic logic [31:0] opb();
    return alusrc ? imm : fwd(forward_b, rs2_data);
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
      3'd1: return 32'((longint'(a) - longint'(b) + 64'h1_0000_0000)
                       % 64'h1_0000_0000);
      3'd2: return a & b;
      3'd3: return a | b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_clear();
    m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0;
    m_rw = 0; m_mw = 0; m_v = 0; m_rs = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".alu"}, alu_result_q, m_alu);
    chk({tag, ".wd"}, write_data_q, m_wd);
    chk({tag, ".pc4"}, pcplus4_q, m_pc4);
    chk({tag, ".rd"}, {27'd0, rd_q}, {27'd0, m_rd});
    chk({tag, ".ctl"}, {28'd0, regwrite_q, memwrite_q, valid_q, 1'b0},
        {28'd0, m_rw, m_mw, m_v, 1'b0});
    chk({tag, ".rs"}, {30'd0, resultsrc_q}, {30'd0, m_rs});
  endtask

  task automatic check_comb(input string tag);
    logic [31:0] a, b;
    logic exp_pcsrc;
    #1;
    a = opa();
    b = opb();
    exp_pcsrc = valid_in && ((branch && (a == b)) || jump);
    chk({tag, ".pcsrc"}, {31'd0, pcsrc}, {31'd0, exp_pcsrc});
    chk({tag, ".tgt"}, pc_target, 32'((longint'(pc) + longint'(imm))
                                      % 64'h1_0000_0000));
  endtask

  // advance one clock, update the model, compare the register
  task automatic step(input string tag);
    logic [31:0] n_alu, n_wd;
    n_alu = alu_ref(alucontrol, opa(), opb());
    n_wd  = fwd(forward_b, rs2_data);
    @(posedge clk);
    if (flush) begin
      model_clear();
    end else if (!stall) begin
      m_alu = n_alu; m_wd = n_wd; m_pc4 = pcplus4; m_rd = rd;
      m_rw = regwrite && valid_in;
      m_mw = memwrite && valid_in;
      m_v = valid_in; m_rs = resultsrc;
    end
    #1;
    check_regs(tag);
  endtask

  task automatic randomize_inputs();
    valid_in   = 1'($urandom);
    alucontrol = 3'($urandom);
    alusrc     = 1'($urandom);
    rs1_data   = $urandom;
    rs2_data   = ($urandom_range(0, 3) == 0) ? rs1_data : $urandom;
    imm        = $urandom;
    pc         = $urandom;
    pcplus4    = pc + 32'd4;
    rd         = 5'($urandom);
    regwrite   = 1'($urandom);
    memwrite   = 1'($urandom);
    branch     = 1'($urandom);
    jump       = ($urandom_range(0, 4) == 0);
    resultsrc  = 2'($urandom);
    forward_a  = 2'($urandom);
    forward_b  = 2'($urandom);
    wb_result  = $urandom;
    stall      = ($urandom_range(0, 5) == 0);
    flush      = ($urandom_range(0, 7) == 0);
  endtask

  task automatic quiet();
    valid_in = 1; alucontrol = 0; alusrc = 0;
    rs1_data = 0; rs2_data = 0; imm = 0; pc = 0; pcplus4 = 4;
    rd = 5'd3; regwrite = 1; memwrite = 0; branch = 0; jump = 0;
    resultsrc = 0; forward_a = 0; forward_b = 0; wb_result = 0;
    stall = 0; flush = 0;
  endtask

  logic [2:0]  ops  [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
  logic [31:0] exps [6] = '{32'h3, 32'h7, 32'h4, 32'hFFFF_FFFF, 32'h0, 32'h0};
  logic [31:0] snap;

  initial begin
    quiet();
    rst_n = 0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    valid_in = 0;
    step("rst_rel");

    // ALU table
    for (int i = 0; i < 6; i++) begin
      quiet();
      rs1_data = 32'h5; rs2_data = 32'hFFFF_FFFE;
      alucontrol = ops[i];
      check_comb("alu_c");
      step("alu");
      chk("alu_tbl", alu_result_q, exps[i]);
    end

    // branch taken, then squashed by valid_in
    quiet();
    branch = 1; rs1_data = 32'h10; rs2_data = 32'h10;
    pc = 32'h100; imm = 32'h20; alucontrol = 3'd1;
    check_comb("br");
    chk("br_pcsrc", {31'd0, pcsrc}, 32'd1);
    chk("br_tgt", pc_target, 32'h120);
    valid_in = 0;
    check_comb("br_nv");
    chk("br_nv_pcsrc", {31'd0, pcsrc}, 32'd0);
    step("br");

    // forwarding
    quiet();
    rs1_data = 32'h55; alusrc = 1; imm = 0;
    step("fw0");
    forward_a = 2'b10; rs1_data = 0; imm = 1;
    forward_b = 2'b01; wb_result = 32'hAA; rs2_data = 32'h33;
    step("fw1");
`ifdef EX_FORWARD_EN
    chk("fw_a", alu_result_q, 32'h56);
    chk("fw_b", write_data_q, 32'hAA);
`else
    chk("nofw_a", alu_result_q, 32'h1);
    chk("nofw_b", write_data_q, 32'h33);
`endif
    forward_a = 2'b10; rs1_data = 7; imm = 0;
    step("fw2");
`ifndef EX_FORWARD_EN
    chk("nofw_a7", alu_result_q, 32'h7);
`endif

    // stall for 3 cycles
    snap = alu_result_q;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      stall = 1; flush = 0;
      step("stall");
    end
    chk("stall_hold", alu_result_q, snap);

    // stall + flush: flush wins
    quiet();
    memwrite = 1; stall = 1; flush = 1;
    step("sf");
    chk("sf_ctl", {29'd0, valid_q, regwrite_q, memwrite_q}, 32'd0);

    // async reset mid-stall
    quiet();
    step("pre_rst");
    stall = 1;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    model_clear();
    check_regs("arst");
    @(negedge clk);
    rst_n = 1;
    stall = 0; valid_in = 0;
    step("arst_rel");
    quiet();
    rs1_data = 32'h9;
    step("arst_cap");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      check_comb("rnd");
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
